// File: rtl/fetch_queue.sv
// fetch_queue: in-order fetch buffer matching OBI responses to granted requests, with credit and flush discard
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64,
  parameter int ILEN  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     issue_i,
  input  logic [XLEN-1:0]          issue_pc_i,
  output logic                     issue_ready_o,
  input  logic                     imem_rvalid_i,
  input  logic [ILEN-1:0]          imem_rdata_i,
  output logic                     out_valid_o,
  output logic [XLEN-1:0]          out_pc_o,
  output logic [XLEN-1:0]          out_next_pc_o,
  output logic [ILEN-1:0]          out_instr_o,
  input  logic                     out_stall_i,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic                     resp_err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {FREE, PEND, RDY} slot_t;
  slot_t           st_q  [DEPTH];
  logic [XLEN-1:0] pc_q  [DEPTH];
  logic [ILEN-1:0] ins_q [DEPTH];
  logic [AW-1:0]   head_q, fill_q, tail_q;
  logic [CW-1:0]   occ_q, pend_q, disc_q, disc_fl;
  logic [CW:0]     fl_sum;
  logic            do_issue, pop, cap, drop;
  always_comb begin
    issue_ready_o = ({1'b0, occ_q} + {1'b0, disc_q}) < (CW+1)'(DEPTH);
    do_issue      = issue_i & issue_ready_o;
    out_valid_o   = st_q[head_q] == RDY;
    pop           = out_valid_o & ~out_stall_i;
    drop          = imem_rvalid_i & (disc_q != '0);
    cap           = imem_rvalid_i & ~drop & (st_q[fill_q] == PEND);
    fl_sum        = {1'b0, disc_q} + {1'b0, pend_q} + (CW+1)'(do_issue);
    disc_fl       = fl_sum > (CW+1)'(imem_rvalid_i) ? CW'(fl_sum - (CW+1)'(imem_rvalid_i)) : '0;
  end
  assign out_pc_o      = pc_q[head_q];
  assign out_next_pc_o = pc_q[head_q] + XLEN'(4);
  assign out_instr_o   = ins_q[head_q];
  assign occupancy_o   = occ_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i]  <= FREE;
        pc_q[i]  <= '0;
        ins_q[i] <= '0;
      end
      head_q     <= '0;
      fill_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      pend_q     <= '0;
      disc_q     <= '0;
      resp_err_o <= 1'b0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) st_q[i] <= FREE;
      fill_q <= head_q;
      tail_q <= head_q;
      occ_q  <= '0;
      pend_q <= '0;
      disc_q <= disc_fl;
    end else begin
      if (do_issue) begin
        st_q[tail_q] <= PEND;
        pc_q[tail_q] <= issue_pc_i;
        tail_q       <= tail_q + 1'b1;
      end
      if (drop) disc_q <= disc_q - 1'b1;
      if (cap) begin
        st_q[fill_q]  <= RDY;
        ins_q[fill_q] <= imem_rdata_i;
        fill_q        <= fill_q + 1'b1;
      end
      if (imem_rvalid_i & ~drop & ~cap) resp_err_o <= 1'b1;
      if (pop) begin
        st_q[head_q] <= FREE;
        head_q       <= head_q + 1'b1;
      end
      occ_q  <= occ_q + CW'(do_issue) - CW'(pop);
      pend_q <= pend_q + CW'(do_issue) - CW'(cap);
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random checks of fetch_queue against a queue-based reference model
module tb_fetch_queue;
  localparam int DEPTH = 4;
  logic        clk_i = 0, rst_i = 1, flush_i = 0, issue_i = 0, imem_rvalid_i = 0, out_stall_i = 0;
  logic [63:0] issue_pc_i = '0, out_pc_o, out_next_pc_o;
  logic [31:0] imem_rdata_i = '0, out_instr_o;
  logic        issue_ready_o, out_valid_o, resp_err_o;
  logic [2:0]  occupancy_o;
  typedef struct {logic [63:0] pc; logic [31:0] ins; bit rdy;} ent_t;
  ent_t        q[$];
  logic [63:0] seen[$];
  int          disc = 0, pass = 0, total = 0;
  bit          err = 0;
  fetch_queue #(.DEPTH(DEPTH), .XLEN(64), .ILEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .issue_i(issue_i), .issue_pc_i(issue_pc_i),
    .issue_ready_o(issue_ready_o), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .out_valid_o(out_valid_o), .out_pc_o(out_pc_o), .out_next_pc_o(out_next_pc_o),
    .out_instr_o(out_instr_o), .out_stall_i(out_stall_i), .occupancy_o(occupancy_o),
    .resp_err_o(resp_err_o));
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic bit exp_valid();
    return q.size() > 0 && q[0].rdy;
  endfunction
  function automatic int pending();
    int n = 0;
    foreach (q[i]) if (!q[i].rdy) n++;
    return n;
  endfunction
  task automatic check_state();
    chk("occupancy", 64'(occupancy_o), 64'(q.size()));
    chk("issue_ready", 64'(issue_ready_o), 64'(q.size() + disc < DEPTH));
    chk("out_valid", 64'(out_valid_o), 64'(exp_valid()));
    chk("resp_err", 64'(resp_err_o), 64'(err));
    if (exp_valid()) begin
      chk("out_pc", out_pc_o, q[0].pc);
      chk("out_next_pc", out_next_pc_o, q[0].pc + 64'd4);
      chk("out_instr", 64'(out_instr_o), 64'(q[0].ins));
    end
  endtask
  task automatic expect_head(input logic [63:0] pc, input logic [63:0] npc, input logic [31:0] ins);
    chk("head_valid", 64'(out_valid_o), 64'd1);
    chk("head_pc", out_pc_o, pc);
    chk("head_next_pc", out_next_pc_o, npc);
    chk("head_instr", 64'(out_instr_o), 64'(ins));
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(out_valid_o), 64'd0);
    chk({tag, "_pc"}, out_pc_o, 64'd0);
    chk({tag, "_next_pc"}, out_next_pc_o, 64'd4);
    chk({tag, "_instr"}, 64'(out_instr_o), 64'd0);
    chk({tag, "_ready"}, 64'(issue_ready_o), 64'd1);
    chk({tag, "_occ"}, 64'(occupancy_o), 64'd0);
    chk({tag, "_err"}, 64'(resp_err_o), 64'd0);
  endtask
  // Called at a falling edge: drive, check pre-edge state, then advance the model across the rising edge.
  task automatic step(input bit fl, input bit iss, input logic [63:0] pc, input bit rv,
                      input logic [31:0] d, input bit st);
    bit pop, diss;
    int idx;
    ent_t e;
    flush_i = fl; issue_i = iss; issue_pc_i = pc; imem_rvalid_i = rv; imem_rdata_i = d; out_stall_i = st;
    #1;
    check_state();
    pop  = exp_valid() && !st;
    diss = iss && (q.size() + disc < DEPTH);
    if (pop) seen.push_back(out_pc_o);
    @(posedge clk_i);
    if (fl) begin
      disc = disc + pending() + int'(diss) - int'(rv);
      if (disc < 0) disc = 0;
      q.delete();
    end else begin
      if (rv) begin
        if (disc > 0) disc--;
        else begin
          idx = -1;
          foreach (q[i]) if (!q[i].rdy && idx < 0) idx = i;
          if (idx >= 0) begin
            e = q[idx]; e.ins = d; e.rdy = 1; q[idx] = e;
          end else err = 1;
        end
      end
      if (pop) void'(q.pop_front());
      if (diss) q.push_back('{pc: pc, ins: 32'd0, rdy: 1'b0});
    end
    @(negedge clk_i);
  endtask
  task automatic idle(input bit st);
    step(0, 0, 64'd0, 0, 32'd0, st);
  endtask
  initial begin
    bit fl, iss, rv, st;
    repeat (2) @(negedge clk_i);
    #1 check_reset_outputs("reset");
    @(negedge clk_i);
    rst_i = 0;
    // basic fill
    step(0, 1, 64'h1000, 0, 32'h0, 0);
    step(0, 1, 64'h1004, 1, 32'hAAA1, 0);
    expect_head(64'h1000, 64'h1004, 32'hAAA1);
    step(0, 1, 64'h1008, 1, 32'hAAA2, 0);
    expect_head(64'h1004, 64'h1008, 32'hAAA2);
    step(0, 0, 64'h0, 1, 32'hAAA3, 0);
    expect_head(64'h1008, 64'h100C, 32'hAAA3);
    idle(0);
    chk("fill_drained", 64'(out_valid_o), 64'd0);
    // full and credit
    step(0, 1, 64'h5000, 0, 32'h0, 1);
    step(0, 1, 64'h5004, 1, 32'hB0, 1);
    step(0, 1, 64'h5008, 1, 32'hB1, 1);
    step(0, 1, 64'h500C, 1, 32'hB2, 1);
    step(0, 0, 64'h0, 1, 32'hB3, 1);
    chk("full_ready", 64'(issue_ready_o), 64'd0);
    chk("full_occ", 64'(occupancy_o), 64'd4);
    step(0, 1, 64'h5FFC, 0, 32'h0, 0);
    chk("credit_back", 64'(issue_ready_o), 64'd1);
    chk("credit_occ", 64'(occupancy_o), 64'd3);
    repeat (4) idle(0);
    // flush with requests in flight
    step(0, 1, 64'h3000, 0, 32'h0, 1);
    step(0, 1, 64'h3004, 1, 32'hC1, 1);
    step(0, 1, 64'h3008, 0, 32'h0, 1);
    step(1, 1, 64'h300C, 0, 32'h0, 1);
    chk("flush_occ", 64'(occupancy_o), 64'd0);
    chk("flush_disc", 64'(disc), 64'd3);
    repeat (3) begin
      step(0, 0, 64'h0, 1, 32'hDEAD, 0);
      chk("discard_valid", 64'(out_valid_o), 64'd0);
    end
    step(0, 1, 64'h2000, 0, 32'h0, 0);
    step(0, 0, 64'h0, 1, 32'hBEEF, 0);
    expect_head(64'h2000, 64'h2004, 32'hBEEF);
    idle(0);
    // response in the flush cycle
    step(0, 1, 64'h4000, 0, 32'h0, 0);
    step(0, 1, 64'h4004, 0, 32'h0, 0);
    step(1, 0, 64'h0, 1, 32'hD0, 0);
    chk("flushrsp_disc", 64'(disc), 64'd1);
    step(0, 0, 64'h0, 1, 32'hD1, 0);
    chk("flushrsp_valid", 64'(out_valid_o), 64'd0);
    step(0, 1, 64'h4100, 0, 32'h0, 0);
    step(0, 0, 64'h0, 1, 32'hC0DE, 0);
    expect_head(64'h4100, 64'h4104, 32'hC0DE);
    chk("flushrsp_err", 64'(resp_err_o), 64'd0);
    idle(0);
    // wrap-around
    seen.delete();
    for (int i = 0; i <= 12; i++)
      step(0, i < 10, 64'h6000 + 64'(4 * i), i >= 1 && i <= 10, 32'h100 + 32'(i), 0);
    chk("wrap_count", 64'(seen.size()), 64'd10);
    foreach (seen[i]) chk("wrap_order", seen[i], 64'h6000 + 64'(4 * i));
    // random traffic
    for (int n = 0; n < 400; n++) begin
      fl  = $urandom_range(0, 24) == 0;
      iss = $urandom_range(0, 2) != 0;
      rv  = (pending() > 0 || disc > 0) && $urandom_range(0, 1) == 1;
      st  = $urandom_range(0, 3) == 0;
      step(fl, iss, {$urandom, $urandom} & ~64'h3, rv, $urandom, st);
    end
    for (int n = 0; n < 40 && (q.size() > 0 || disc > 0); n++)
      step(0, 0, 64'h0, pending() > 0 || disc > 0, $urandom, 0);
    chk("drained_occ", 64'(occupancy_o), 64'd0);
    // unexpected response
    chk("err_before", 64'(resp_err_o), 64'd0);
    step(0, 0, 64'h0, 1, 32'hE, 0);
    chk("err_set", 64'(resp_err_o), 64'd1);
    idle(0);
    chk("err_held", 64'(resp_err_o), 64'd1);
    // asynchronous reset mid-stream
    step(0, 1, 64'h7000, 0, 32'h0, 1);
    step(0, 1, 64'h7004, 1, 32'h77, 1);
    chk("pre_reset_valid", 64'(out_valid_o), 64'd1);
    rst_i = 1; flush_i = 0; issue_i = 0; imem_rvalid_i = 0; out_stall_i = 0;
    #1 check_reset_outputs("async_reset");
    q.delete(); disc = 0; err = 0;
    @(negedge clk_i);
    rst_i = 0;
    idle(0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
